im_fetch_ctrl: RTL and testbench
================================

// Module: im_fetch_ctrl
// PURPOSE
//  Upstream sequencer and output stage for item_memory. Accepts fetch bursts
//  (A/B start addresses, length, increment flags, CiM select), walks the address
//  sequence into item_memory's combinational address ports, and registers the
//  returned A/B hypervectors into a valid/ready output stage for the encoder.
// PARAMETERS
//  HVDimension  512  hypervector width, matches item_memory
//  ImAddrWidth  32   width of A/B item-memory addresses
//  LenWidth     16   width of burst length field
// PORTS
//  clk_i        in   1            clock
//  rst_i        in   1            async reset, active-high
//  clr_i        in   1            sync abort: drop burst and output beat
//  req_valid_i  in   1            burst request valid
//  req_ready_o  out  1            burst request accepted (high only in IDLE)
//  req_a_addr_i in   ImAddrWidth  start address, port A (CiM level if req_cim_i)
//  req_b_addr_i in   ImAddrWidth  start address, port B
//  req_len_i    in   LenWidth     beats in burst; 0 treated as 1
//  req_a_inc_i  in   1            increment A address per beat
//  req_b_inc_i  in   1            increment B address per beat
//  req_cim_i    in   1            port A reads CiM instead of iM
//  port_a_cim_o out  1            to item_memory port_a_cim_i
//  im_a_addr_o  out  ImAddrWidth  to item_memory im_a_addr_i
//  im_b_addr_o  out  ImAddrWidth  to item_memory im_b_addr_i
//  im_a_i       in   HVDimension  from item_memory im_a_o
//  im_b_i       in   HVDimension  from item_memory im_b_o
//  out_valid_o  out  1            output beat valid
//  out_ready_i  in   1            downstream ready
//  out_a_o      out  HVDimension  registered A hypervector
//  out_b_o      out  HVDimension  registered B hypervector
//  out_last_o   out  1            final beat of burst
//  busy_o       out  1            state==RUN or out_valid_o
// BEHAVIOUR
//  - Reset: state IDLE, all counters/address regs 0, every output 0 except
//    req_ready_o=1.
//  - States IDLE, RUN. IDLE: req_ready_o=1; req_valid_i&&req_ready_o latches
//    addresses, flags, cim, remaining=max(len,1) -> RUN.
//  - RUN: issue = !out_valid_o || out_ready_i. On issue: out_a/out_b <= im_a_i/
//    im_b_i, out_valid_o<=1, out_last_o<=(remaining==1); remaining--; advance
//    addresses per inc flags. Issue of last beat -> IDLE (next request takes
//    effect one cycle later; one-cycle gap between bursts is required).
//  - Addresses/port_a_cim_o driven from registers; zero in IDLE. Latency: one
//    cycle from address presentation to out_valid_o.
//  - Output beat holds stable while out_valid_o && !out_ready_i; out_valid_o
//    clears on handshake with no new issue. Full throughput 1 beat/cycle.
//  - B address increment wraps modulo 2^ImAddrWidth. A address wraps likewise
//    in iM mode; in CiM mode it saturates at HVDimension/2-1.
//  - clr_i (priority over all): state IDLE, out_valid_o/out_last_o 0, request
//    not accepted that cycle. Async reset mid-burst: same as reset values.
//  - Data paths not reset-critical; data regs reset to 0.
// STRUCTURE
//  - Shared package im_fetch_pkg: state enum (IDLE, RUN), CimLevels constant.
//  - Single sub-module im_out_reg: valid/ready output register for A/B/last.
//  - Address/length counters and FSM in top level; item_memory instantiated
//    by parent, not inside this block.
// TESTING
//  - Reset: assert rst_i mid-burst -> outputs 0, req_ready_o=1 same cycle.
//  - Burst A=5,B=100,len=4,both inc, out_ready=1 -> 4 beats addr A 5..8, B
//    100..103, out_last_o on beat 4 only, 4 consecutive cycles.
//  - len=0 -> exactly one beat with out_last_o=1.
//  - Backpressure: out_ready_i low 3 cycles on beat 2 -> beat 2 data stable,
//    addresses held, no beat lost or duplicated.
//  - CiM mode A=254, HVDimension=512, len=4, a_inc -> A addr 254,255,255,255;
//    B=0xFFFF_FFFE inc -> 0xFFFF_FFFE,0xFFFF_FFFF,0,1.
//  - clr_i during beat 3 of len=8 -> out_valid_o 0 next cycle, IDLE, new
//    request accepted and runs cleanly.

Source files
------------

// File: rtl/im_fetch_pkg.sv
// Shared types and constants for the item-memory fetch controller.
package im_fetch_pkg;

   // Burst sequencer states.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Number of continuous item-memory levels for a given hypervector width.
   function automatic int unsigned cim_levels(input int unsigned hv_dim);
      return hv_dim / 2;
   endfunction

   // CiM level count for the default 512-bit hypervector.
   localparam int unsigned CimLevels = cim_levels(512);

endpackage

// File: rtl/im_out_reg.sv
// Valid/ready output register holding one A/B hypervector beat and its last flag.
module im_out_reg
   import im_fetch_pkg::*;
#(
   parameter int unsigned HVDimension = 512
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   load_i,
   input  logic [HVDimension-1:0] a_i,
   input  logic [HVDimension-1:0] b_i,
   input  logic                   last_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [HVDimension-1:0] a_o,
   output logic [HVDimension-1:0] b_o,
   output logic                   last_o
);

   logic                   valid_q;
   logic                   last_q;
   logic [HVDimension-1:0] a_q;
   logic [HVDimension-1:0] b_q;

   // Capture a new beat on load, hold it under backpressure, drop it on handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         last_q  <= last_i;
         a_q     <= a_i;
         b_q     <= b_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign a_o     = a_q;
   assign b_o     = b_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Burst address sequencer for item_memory with a registered valid/ready output stage.
module im_fetch_ctrl
   import im_fetch_pkg::*;
#(
   parameter int unsigned HVDimension = 512,
   parameter int unsigned ImAddrWidth = 32,
   parameter int unsigned LenWidth    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [ImAddrWidth-1:0] req_a_addr_i,
   input  logic [ImAddrWidth-1:0] req_b_addr_i,
   input  logic [LenWidth-1:0]    req_len_i,
   input  logic                   req_a_inc_i,
   input  logic                   req_b_inc_i,
   input  logic                   req_cim_i,
   output logic                   port_a_cim_o,
   output logic [ImAddrWidth-1:0] im_a_addr_o,
   output logic [ImAddrWidth-1:0] im_b_addr_o,
   input  logic [HVDimension-1:0] im_a_i,
   input  logic [HVDimension-1:0] im_b_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [HVDimension-1:0] out_a_o,
   output logic [HVDimension-1:0] out_b_o,
   output logic                   out_last_o,
   output logic                   busy_o
);

   // Highest CiM level; the A address saturates here in CiM mode.
   localparam logic [ImAddrWidth-1:0] CimMax = ImAddrWidth'(cim_levels(HVDimension) - 1);

   state_e                 state_q;
   logic                   req_ready_q;
   logic [ImAddrWidth-1:0] a_addr_q, a_addr_d;
   logic [ImAddrWidth-1:0] b_addr_q, b_addr_d;
   logic                   a_inc_q, b_inc_q, cim_q;
   logic [LenWidth-1:0]    rem_q;
   logic                   issue;
   logic                   last_beat;
   logic                   running;
   logic                   out_valid;

   assign running   = (state_q == RUN);
   assign last_beat = (rem_q == LenWidth'(1));
   // A beat is issued whenever the output register is empty or being drained.
   assign issue     = running && !clr_i && (!out_valid || out_ready_i);

   // Next A/B addresses: B wraps freely; A wraps in iM mode, saturates in CiM mode.
   always_comb begin
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q + ImAddrWidth'(b_inc_q);
      if (a_inc_q) begin
         if (!cim_q || (a_addr_q < CimMax)) begin
            a_addr_d = a_addr_q + ImAddrWidth'(1);
         end
      end
   end

   // Burst FSM: latch request in IDLE, walk addresses and count beats in RUN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         a_addr_q    <= '0;
         b_addr_q    <= '0;
         a_inc_q     <= 1'b0;
         b_inc_q     <= 1'b0;
         cim_q       <= 1'b0;
         rem_q       <= '0;
      end else if (clr_i) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rem_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i && req_ready_q) begin
                  state_q     <= RUN;
                  req_ready_q <= 1'b0;
                  a_addr_q    <= req_a_addr_i;
                  b_addr_q    <= req_b_addr_i;
                  a_inc_q     <= req_a_inc_i;
                  b_inc_q     <= req_b_inc_i;
                  cim_q       <= req_cim_i;
                  rem_q       <= (req_len_i == '0) ? LenWidth'(1) : req_len_i;
               end
            end
            RUN: begin
               if (issue) begin
                  rem_q    <= rem_q - LenWidth'(1);
                  a_addr_q <= a_addr_d;
                  b_addr_q <= b_addr_d;
                  if (last_beat) begin
                     state_q     <= IDLE;
                     req_ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   im_out_reg #(
      .HVDimension(HVDimension)
   ) u_out_reg (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (clr_i),
      .load_i (issue),
      .a_i    (im_a_i),
      .b_i    (im_b_i),
      .last_i (last_beat),
      .ready_i(out_ready_i),
      .valid_o(out_valid),
      .a_o    (out_a_o),
      .b_o    (out_b_o),
      .last_o (out_last_o)
   );

   assign req_ready_o  = req_ready_q;
   assign out_valid_o  = out_valid;
   assign im_a_addr_o  = running ? a_addr_q : '0;
   assign im_b_addr_o  = running ? b_addr_q : '0;
   assign port_a_cim_o = running & cim_q;
   assign busy_o       = running | out_valid;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed testbench for im_fetch_ctrl with a simple combinational item-memory stand-in.
module tb_im_fetch_ctrl;

   localparam int unsigned HV = 512;
   localparam int unsigned AW = 32;
   localparam int unsigned LW = 16;

   logic          clk = 1'b0;
   logic          rst_i, clr_i;
   logic          req_valid_i, req_ready_o;
   logic [AW-1:0] req_a_addr_i, req_b_addr_i;
   logic [LW-1:0] req_len_i;
   logic          req_a_inc_i, req_b_inc_i, req_cim_i;
   logic          port_a_cim_o;
   logic [AW-1:0] im_a_addr_o, im_b_addr_o;
   logic [HV-1:0] im_a_i, im_b_i;
   logic          out_valid_o, out_ready_i;
   logic [HV-1:0] out_a_o, out_b_o;
   logic          out_last_o, busy_o;

   int nerr = 0;
   int nchk = 0;

   logic [AW-1:0] exp_a [16];
   logic [AW-1:0] exp_b [16];

   always #5 clk = ~clk;

   im_fetch_ctrl #(.HVDimension(HV), .ImAddrWidth(AW), .LenWidth(LW)) dut (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_addr_i(req_a_addr_i), .req_b_addr_i(req_b_addr_i), .req_len_i(req_len_i),
      .req_a_inc_i(req_a_inc_i), .req_b_inc_i(req_b_inc_i), .req_cim_i(req_cim_i),
      .port_a_cim_o(port_a_cim_o), .im_a_addr_o(im_a_addr_o), .im_b_addr_o(im_b_addr_o),
      .im_a_i(im_a_i), .im_b_i(im_b_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_a_o(out_a_o), .out_b_o(out_b_o), .out_last_o(out_last_o), .busy_o(busy_o)
   );

   // Item-memory stand-in: A carries {cim, addr} in its low bits, B carries addr in its high bits.
   function automatic logic [HV-1:0] mk_a(input logic [AW-1:0] addr, input logic cim);
      return {{(HV-AW-1){1'b0}}, cim, addr};
   endfunction

   function automatic logic [HV-1:0] mk_b(input logic [AW-1:0] addr);
      return {addr, {(HV-AW){1'b0}}};
   endfunction

   assign im_a_i = mk_a(im_a_addr_o, port_a_cim_o);
   assign im_b_i = mk_b(im_b_addr_o);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [LW-1:0] len,
                           input logic ainc, input logic binc, input logic cim);
      int n = 0;
      while (!req_ready_o && n < 50) begin
         step();
         n++;
      end
      nchk++;
      if (req_ready_o !== 1'b1) begin
         nerr++;
         $display("FAIL req_ready_wait: req_ready_o=%b required 1", req_ready_o);
      end
      req_a_addr_i = a; req_b_addr_i = b; req_len_i = len;
      req_a_inc_i = ainc; req_b_inc_i = binc; req_cim_i = cim;
      req_valid_i = 1'b1;
      step();
      req_valid_i = 1'b0;
   endtask

   // Collect n beats against exp_a/exp_b; optionally stall beat stall_beat for stall_cycles cycles.
   task automatic collect(input string name, input int n, input logic cim,
                          input int stall_beat, input int stall_cycles);
      int beat = 0;
      int cyc = 0;
      int last_cyc = -1;
      int stall_left = stall_cycles;
      logic [AW-1:0] held_addr = '0;
      while (beat < n && cyc < 60) begin
         if (out_valid_o) begin
            if (beat == stall_beat && stall_left > 0) begin
               out_ready_i = 1'b0;
               if (stall_left == stall_cycles) held_addr = im_a_addr_o;
               nchk++;
               if (out_a_o !== mk_a(exp_a[beat], cim) || out_b_o !== mk_b(exp_b[beat])) begin
                  nerr++;
                  $display("FAIL %s_stall_data beat%0d: a=%h b=%h required a_addr=%h b_addr=%h",
                           name, beat, out_a_o[AW:0], out_b_o[HV-1 -: AW], exp_a[beat], exp_b[beat]);
               end
               nchk++;
               if (im_a_addr_o !== held_addr) begin
                  nerr++;
                  $display("FAIL %s_stall_addr: im_a_addr=%h required %h", name, im_a_addr_o, held_addr);
               end
               stall_left--;
            end else begin
               out_ready_i = 1'b1;
               nchk++;
               if (out_a_o !== mk_a(exp_a[beat], cim) || out_b_o !== mk_b(exp_b[beat]) ||
                   out_last_o !== (beat == n-1)) begin
                  nerr++;
                  $display("FAIL %s_beat%0d: a_addr=%h b_addr=%h last=%b required a_addr=%h b_addr=%h last=%b",
                           name, beat, out_a_o[AW-1:0], out_b_o[HV-1 -: AW], out_last_o,
                           exp_a[beat], exp_b[beat], (beat == n-1));
               end
               if (stall_beat < 0 && beat > 0) begin
                  nchk++;
                  if (cyc != last_cyc + 1) begin
                     nerr++;
                     $display("FAIL %s_gap beat%0d: cycle=%0d required %0d", name, beat, cyc, last_cyc + 1);
                  end
               end
               last_cyc = cyc;
               beat++;
            end
         end else begin
            out_ready_i = 1'b1;
         end
         step();
         cyc++;
      end
      nchk++;
      if (beat != n) begin
         nerr++;
         $display("FAIL %s_timeout: beats=%0d required %0d", name, beat, n);
      end
      nchk++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1 || im_a_addr_o !== '0) begin
         nerr++;
         $display("FAIL %s_end: valid=%b busy=%b ready=%b a_addr=%h required 0 0 1 0",
                  name, out_valid_o, busy_o, req_ready_o, im_a_addr_o);
      end
   endtask

   task automatic test_reset();
      nchk++;
      if (req_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_last_o !== 1'b0 ||
          im_a_addr_o !== '0 || im_b_addr_o !== '0 || port_a_cim_o !== 1'b0 ||
          out_a_o !== '0 || out_b_o !== '0) begin
         nerr++;
         $display("FAIL reset_state: ready=%b valid=%b busy=%b last=%b required 1 0 0 0",
                  req_ready_o, out_valid_o, busy_o, out_last_o);
      end
      send_req(32'd7, 32'd9, 16'd8, 1'b1, 1'b1, 1'b1);
      out_ready_i = 1'b1;
      step(); step(); step();
      nchk++;
      if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
         nerr++;
         $display("FAIL reset_preburst: valid=%b busy=%b required 1 1", out_valid_o, busy_o);
      end
      #2 rst_i = 1'b1;
      #1;
      nchk++;
      if (req_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_last_o !== 1'b0 ||
          im_a_addr_o !== '0 || im_b_addr_o !== '0 || port_a_cim_o !== 1'b0 ||
          out_a_o !== '0 || out_b_o !== '0) begin
         nerr++;
         $display("FAIL reset_midburst: ready=%b valid=%b busy=%b a_addr=%h required 1 0 0 0",
                  req_ready_o, out_valid_o, busy_o, im_a_addr_o);
      end
      step();
      rst_i = 1'b0;
      step();
      nchk++;
      if (busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
         nerr++;
         $display("FAIL reset_release: busy=%b ready=%b required 0 1", busy_o, req_ready_o);
      end
   endtask

   task automatic test_burst();
      for (int i = 0; i < 4; i++) begin
         exp_a[i] = 32'd5 + i;
         exp_b[i] = 32'd100 + i;
      end
      send_req(32'd5, 32'd100, 16'd4, 1'b1, 1'b1, 1'b0);
      collect("burst", 4, 1'b0, -1, 0);
   endtask

   task automatic test_len0();
      exp_a[0] = 32'd33;
      exp_b[0] = 32'd44;
      send_req(32'd33, 32'd44, 16'd0, 1'b1, 1'b1, 1'b0);
      collect("len0", 1, 1'b0, -1, 0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) begin
         exp_a[i] = 32'd5 + i;
         exp_b[i] = 32'd100 + i;
      end
      send_req(32'd5, 32'd100, 16'd4, 1'b1, 1'b1, 1'b0);
      collect("bp", 4, 1'b0, 1, 3);
   endtask

   task automatic test_cim();
      exp_a[0] = 32'd254; exp_a[1] = 32'd255; exp_a[2] = 32'd255; exp_a[3] = 32'd255;
      exp_b[0] = 32'hFFFF_FFFE; exp_b[1] = 32'hFFFF_FFFF; exp_b[2] = 32'd0; exp_b[3] = 32'd1;
      send_req(32'd254, 32'hFFFF_FFFE, 16'd4, 1'b1, 1'b1, 1'b1);
      collect("cim", 4, 1'b1, -1, 0);
   endtask

   task automatic test_clr();
      int n = 0;
      send_req(32'd10, 32'd20, 16'd8, 1'b1, 1'b1, 1'b0);
      out_ready_i = 1'b1;
      while (!(out_valid_o && out_a_o === mk_a(32'd12, 1'b0)) && n < 20) begin
         step();
         n++;
      end
      nchk++;
      if (out_a_o !== mk_a(32'd12, 1'b0) || out_valid_o !== 1'b1) begin
         nerr++;
         $display("FAIL clr_beat3: a_addr=%h valid=%b required 0000000c 1", out_a_o[AW-1:0], out_valid_o);
      end
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      nchk++;
      if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || busy_o !== 1'b0 ||
          req_ready_o !== 1'b1 || im_a_addr_o !== '0) begin
         nerr++;
         $display("FAIL clr_abort: valid=%b last=%b busy=%b ready=%b required 0 0 0 1",
                  out_valid_o, out_last_o, busy_o, req_ready_o);
      end
      exp_a[0] = 32'd40; exp_a[1] = 32'd40;
      exp_b[0] = 32'd50; exp_b[1] = 32'd51;
      send_req(32'd40, 32'd50, 16'd2, 1'b0, 1'b1, 1'b0);
      collect("after_clr", 2, 1'b0, -1, 0);
   endtask

   initial begin
      rst_i = 1'b1; clr_i = 1'b0; req_valid_i = 1'b0;
      req_a_addr_i = '0; req_b_addr_i = '0; req_len_i = '0;
      req_a_inc_i = 1'b0; req_b_inc_i = 1'b0; req_cim_i = 1'b0;
      out_ready_i = 1'b1;
      step(); step();
      rst_i = 1'b0;
      step();
      test_reset();
      test_burst();
      test_len0();
      test_backpressure();
      test_cim();
      test_clr();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
